pattern_player: RTL and testbench
=================================

// Module: pattern_player
// PURPOSE
//  Replays stored FPU test vectors {A,B,Sel,round,Y_exp} into the FPU and checks its results.
//  Reads what the vector dump writes: one packed 100-bit hex word per line, {A,B,Sel,round,Y}.
//  Sits in the bench between the vector memory and the FPU top.
//  Drives operands and a start pulse, waits for done, compares Y and accumulates pass/fail/error counts.
// PARAMETERS
//  DEPTH    1024           max vectors held in internal memory
//  AW       10             address width, clog2(DEPTH)
//  PATFILE  "pattern.hex"  $readmemh image, 25 hex digits per line
//  TIMEOUT  64             max cycles from start to done before the vector is declared failed
// PORTS
//  Clock      in   1   single clock; all state on rising edge
//  Reset      in   1   asynchronous, active-high; clears all state
//  run        in   1   level; leaving IDLE requires run=1
//  num_vec    in   AW+1  vector count, sampled on IDLE->LOAD; clamped to DEPTH
//  Y          in   32  FPU result
//  Error      in   1   FPU error flag, valid with done
//  Overflow   in   1   FPU overflow flag, valid with done
//  done       in   1   FPU result-valid strobe, 1 cycle
//  A, B       out  32  operands, held stable from ISSUE through CHECK
//  Sel        out  2   operation select
//  round      out  2   rounding mode
//  start      out  1   1-cycle pulse per vector
//  busy       out  1   high in every state except IDLE and DONE
//  mismatch   out  1   1-cycle pulse in CHECK when Y != Y_exp or timeout
//  pass_cnt   out  AW+1  vectors with Y == Y_exp
//  fail_cnt   out  AW+1  mismatches plus timeouts
//  err_cnt    out  AW+1  vectors returned with Error=1; Y not compared
//  ovf_cnt    out  AW+1  vectors returned with Overflow=1; informational only
//  FIN        out  1   high in DONE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx=0.
//  FSM: IDLE -> LOAD -> ISSUE -> WAIT -> CHECK -> (LOAD | DONE).
//  IDLE: when run=1, latch n=min(num_vec,DEPTH) and clear all counters.
//   n==0 -> DONE directly; otherwise -> LOAD.
//  LOAD: registered memory read of mem[idx]; takes 1 cycle.
//  ISSUE: drive A/B/Sel/round from the word and assert start for exactly this cycle.
//   Clear the timeout counter.
//  WAIT: sample done from the cycle after ISSUE onward; done seen during ISSUE is ignored.
//   On done: capture Y, Error and Overflow -> CHECK.
//   On tcnt == TIMEOUT-1 without done: set timeout flag -> CHECK.
//  CHECK (1 cycle), first matching rule wins:
//   timeout -> fail_cnt++ and mismatch=1.
//   else Error=1 -> err_cnt++.
//   else Y==Y_exp -> pass_cnt++.
//   else -> fail_cnt++ and mismatch=1.
//   Overflow=1 additionally increments ovf_cnt.
//   Then idx++; idx==n -> DONE, else -> LOAD.
//  Per-vector latency without stall: LOAD 1 + ISSUE 1 + WAIT (DUT latency) + CHECK 1.
//  DONE: FIN=1; counters held. run=0 -> IDLE, FIN drops, counters kept until the next run.
//  run dropping mid-sequence is ignored; only Reset aborts.
//   Reset mid-sequence clears immediately, including a start pulse in flight.
//  Comparison is a 32-bit bitwise equality, with no NaN or sign-of-zero exceptions.
//  Counters cannot wrap because n <= DEPTH and the counters are AW+1 bits wide.
//  Extra done pulses outside WAIT are ignored.
// STRUCTURE
//  Shared package fpu_tb_pkg: VEC_W=100, field offsets (A[99:68] B[67:36] Sel[35:34]
//   round[33:32] Y[31:0]), state encoding localparams.
//  One sub-module: pattern_rom (DEPTH x VEC_W, $readmemh PATFILE, registered read port).
//  FSM, timeout counter and scoreboard counters live in the top module.
// TESTING
//  1. n=3, DUT model with 2-cycle latency returning exact Y -> pass_cnt=3, fail_cnt=0, FIN at cycle 3*5+1.
//  2. Vector 1 returns Y=0x3F800001 vs expected 0x3F800000 -> mismatch pulse once, fail_cnt=1, pass_cnt=2.
//  3. DUT never asserts done, TIMEOUT=8 -> CHECK 8 cycles after start, fail_cnt=1, sequence continues.
//  4. done with Error=1 and garbage Y -> err_cnt=1, fail_cnt=0; Overflow=1 -> ovf_cnt=1.
//  5. num_vec=0 -> FIN next cycle with no start pulse; num_vec=2047 with DEPTH=1024 -> exactly 1024 starts.
//  6. Reset asserted in WAIT on vector 5 -> all outputs 0 same cycle; rerun restarts at idx 0.

Source files
------------

// File: rtl/pattern_player_pkg.sv
// ---------------------------------------------------------------------------
// pattern_player_pkg
// Shared definitions for the FPU vector replayer.
//   VEC_W   : width of one stored test vector (25 hex digits)
//   vec_t   : packed view of a vector, {A, B, Sel, round, Y_exp}, MSB first
//             A[99:68] B[67:36] Sel[35:34] round[33:32] Y[31:0]
//   state_t : replay FSM states
// ---------------------------------------------------------------------------
package pattern_player_pkg;

  localparam int VEC_W = 100;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [1:0]  rnd;
    logic [31:0] y;
  } vec_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/pattern_player_rom.sv
// ---------------------------------------------------------------------------
// pattern_player_rom
// Vector store of DEPTH x VEC_W words with a registered read port. The image
// is written through the load port by whoever owns the vector dump, one
// packed {A,B,Sel,round,Y} word per address.
// Ports:
//   i_clk, i_rst          clock, async active-high reset (clears read register)
//   i_wr_en/addr/data     load port, one word per cycle
//   i_rd_en, i_rd_addr    read request; data appears the following cycle
//   o_rd_data             registered read data, held while i_rd_en is low
// ---------------------------------------------------------------------------
module pattern_player_rom
  import pattern_player_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [VEC_W-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [VEC_W-1:0] o_rd_data
);

  logic [VEC_W-1:0] r_mem [DEPTH];
  logic [VEC_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read data only updates on a request, so the operands taken from it stay
  // stable for the whole time a vector is in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pattern_player.sv
// ---------------------------------------------------------------------------
// pattern_player
// Replays stored FPU test vectors into an FPU, waits for each result, compares
// it with the stored expectation and keeps pass/fail/error/overflow tallies.
// Ports:
//   i_clk, i_rst       clock, async active-high reset
//   i_run              level; starts a replay from IDLE, releases DONE
//   i_num_vec          vectors to replay, clamped to DEPTH
//   i_ld_*             vector memory load port
//   i_y, i_error,
//   i_overflow, i_done FPU result interface
//   o_a, o_b, o_sel,
//   o_round, o_start   FPU operand interface, one start pulse per vector
//   o_busy             high while a replay is in progress
//   o_mismatch         one-cycle pulse on a wrong result or timeout
//   o_*_cnt            scoreboard counters
//   o_fin              high once the replay has finished
// ---------------------------------------------------------------------------
module pattern_player
  import pattern_player_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [AW:0]      i_num_vec,
  input  logic             i_ld_en,
  input  logic [AW-1:0]    i_ld_addr,
  input  logic [VEC_W-1:0] i_ld_data,
  input  logic [31:0]      i_y,
  input  logic             i_error,
  input  logic             i_overflow,
  input  logic             i_done,
  output logic [31:0]      o_a,
  output logic [31:0]      o_b,
  output logic [1:0]       o_sel,
  output logic [1:0]       o_round,
  output logic             o_start,
  output logic             o_busy,
  output logic             o_mismatch,
  output logic [AW:0]      o_pass_cnt,
  output logic [AW:0]      o_fail_cnt,
  output logic [AW:0]      o_err_cnt,
  output logic [AW:0]      o_ovf_cnt,
  output logic             o_fin
);

  localparam int          TW      = $clog2(TIMEOUT) + 1;
  // The start cycle is the first cycle of the timeout window and the counter
  // starts at zero in the first WAIT cycle, so the window closes at TIMEOUT-2.
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 2);
  localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);

  state_t           r_state;
  logic [AW:0]      r_n;
  logic [AW:0]      r_idx;
  logic [TW-1:0]    r_tcnt;
  logic             r_timeout;
  logic [31:0]      r_y;
  logic             r_err;
  logic             r_ovf;
  logic             r_start;
  logic             r_busy;
  logic             r_mismatch;
  logic             r_fin;
  logic [AW:0]      r_pass_cnt;
  logic [AW:0]      r_fail_cnt;
  logic [AW:0]      r_err_cnt;
  logic [AW:0]      r_ovf_cnt;

  logic [VEC_W-1:0] w_rom_data;
  vec_t             w_vec;
  logic [AW:0]      w_n_clamped;
  logic [AW:0]      w_idx_next;

  pattern_player_rom #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rom (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_ld_en),
    .i_wr_addr (i_ld_addr),
    .i_wr_data (i_ld_data),
    .i_rd_en   (r_state == S_LOAD),
    .i_rd_addr (r_idx[AW-1:0]),
    .o_rd_data (w_rom_data)
  );

  assign w_vec       = vec_t'(w_rom_data);
  assign w_n_clamped = (i_num_vec > DEPTH_N) ? DEPTH_N : i_num_vec;
  assign w_idx_next  = r_idx + ONE;

  // Replay FSM with timeout counter and scoreboard. The mismatch pulse is
  // decided on the way into CHECK so it is visible during CHECK, while the
  // counters are updated from the captured result at the end of CHECK.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_idx      <= '0;
      r_tcnt     <= '0;
      r_timeout  <= 1'b0;
      r_y        <= '0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_mismatch <= 1'b0;
      r_fin      <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_err_cnt  <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      r_start    <= 1'b0;
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_n        <= w_n_clamped;
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_err_cnt  <= '0;
            r_ovf_cnt  <= '0;
            if (w_n_clamped == '0) begin
              r_state <= S_DONE;
              r_fin   <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_ISSUE;
          r_start <= 1'b1;
        end
        S_ISSUE: begin
          // A done strobe during ISSUE belongs to nothing we issued; ignore it.
          r_tcnt    <= '0;
          r_timeout <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (i_done) begin
            r_y        <= i_y;
            r_err      <= i_error;
            r_ovf      <= i_overflow;
            r_mismatch <= !i_error && (i_y != w_vec.y);
            r_state    <= S_CHECK;
          end else if (r_tcnt == T_LAST) begin
            r_timeout  <= 1'b1;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_mismatch <= 1'b1;
            r_state    <= S_CHECK;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (r_timeout) begin
            r_fail_cnt <= r_fail_cnt + ONE;
          end else if (r_err) begin
            r_err_cnt <= r_err_cnt + ONE;
          end else if (r_y == w_vec.y) begin
            r_pass_cnt <= r_pass_cnt + ONE;
          end else begin
            r_fail_cnt <= r_fail_cnt + ONE;
          end
          if (r_ovf) begin
            r_ovf_cnt <= r_ovf_cnt + ONE;
          end
          r_idx <= w_idx_next;
          if (w_idx_next == r_n) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_fin   <= 1'b1;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_DONE: begin
          if (!i_run) begin
            r_state <= S_IDLE;
            r_fin   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_fin   <= 1'b0;
        end
      endcase
    end
  end

  assign o_a        = w_vec.a;
  assign o_b        = w_vec.b;
  assign o_sel      = w_vec.sel;
  assign o_round    = w_vec.rnd;
  assign o_start    = r_start;
  assign o_busy     = r_busy;
  assign o_mismatch = r_mismatch;
  assign o_pass_cnt = r_pass_cnt;
  assign o_fail_cnt = r_fail_cnt;
  assign o_err_cnt  = r_err_cnt;
  assign o_ovf_cnt  = r_ovf_cnt;
  assign o_fin      = r_fin;

endmodule

// File: tb/tb_pattern_player.sv
// ---------------------------------------------------------------------------
// tb_pattern_player
// Self-checking bench for pattern_player. A behavioural FPU responder answers
// each start pulse according to a per-vector behaviour table, and a reference
// model derives expected counters and finish time from that table.
// ---------------------------------------------------------------------------
module tb_pattern_player;

  localparam int DEPTH   = 1024;
  localparam int AW      = 10;
  localparam int TIMEOUT = 8;

  // Per-vector FPU behaviours
  localparam int M_OK     = 0;
  localparam int M_BADY   = 1;
  localparam int M_NODONE = 2;
  localparam int M_ERR    = 3;
  localparam int M_EARLY  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [AW:0]   numVec = '0;
  logic          ldEn = 1'b0;
  logic [AW-1:0] ldAddr = '0;
  logic [99:0]   ldData = '0;
  logic [31:0]   fpuY = '0;
  logic          fpuErr = 1'b0;
  logic          fpuOvf = 1'b0;
  logic          fpuDone = 1'b0;

  logic [31:0]   opA, opB;
  logic [1:0]    opSel, opRnd;
  logic          start, busy, mismatch, fin;
  logic [AW:0]   passCnt, failCnt, errCnt, ovfCnt;

  int nChecks = 0;
  int nErrors = 0;

  logic [99:0] vecMem [DEPTH];
  int          modeArr [DEPTH];
  int          latArr [DEPTH];
  bit          ovfArr [DEPTH];
  logic [31:0] yBad [DEPTH];
  int          startCycle [DEPTH];

  int startCnt = 0;
  int mmCnt = 0;
  int mmCycle = -1;
  int opErr = 0;
  int cycleCnt = 0;
  int pend = 0;
  int curVec = 0;

  pattern_player #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_run      (run),
    .i_num_vec  (numVec),
    .i_ld_en    (ldEn),
    .i_ld_addr  (ldAddr),
    .i_ld_data  (ldData),
    .i_y        (fpuY),
    .i_error    (fpuErr),
    .i_overflow (fpuOvf),
    .i_done     (fpuDone),
    .o_a        (opA),
    .o_b        (opB),
    .o_sel      (opSel),
    .o_round    (opRnd),
    .o_start    (start),
    .o_busy     (busy),
    .o_mismatch (mismatch),
    .o_pass_cnt (passCnt),
    .o_fail_cnt (failCnt),
    .o_err_cnt  (errCnt),
    .o_ovf_cnt  (ovfCnt),
    .o_fin      (fin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // FPU responder and monitor, acting on the falling edge so every response
  // is settled well before the player samples it.
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      fpuDone = 1'b0;
      fpuErr = 1'b0;
      fpuOvf = 1'b0;
    end else begin
      fpuDone = 1'b0;
      fpuErr = 1'b0;
      fpuOvf = 1'b0;
      fpuY = $urandom;
      if (mismatch) begin
        mmCnt++;
        mmCycle = cycleCnt;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (opA !== vecMem[curVec][99:68] || opB !== vecMem[curVec][67:36]) opErr++;
          fpuDone = 1'b1;
          fpuOvf = ovfArr[curVec];
          if (modeArr[curVec] == M_ERR) begin
            fpuErr = 1'b1;
          end else if (modeArr[curVec] == M_BADY) begin
            fpuY = yBad[curVec];
          end else begin
            fpuY = vecMem[curVec][31:0];
          end
        end
      end
      if (start) begin
        curVec = (startCnt < DEPTH) ? startCnt : DEPTH - 1;
        startCnt++;
        startCycle[curVec] = cycleCnt;
        if ({opA, opB, opSel, opRnd} !== vecMem[curVec][99:32]) opErr++;
        if (modeArr[curVec] != M_NODONE) pend = latArr[curVec];
        if (modeArr[curVec] == M_EARLY) begin
          fpuDone = 1'b1;
          fpuErr = 1'b1;
          fpuY = ~vecMem[curVec][31:0];
        end
      end
    end
  end

  task automatic loadOne(input int i);
    @(negedge clk);
    ldEn = 1'b1;
    ldAddr = AW'(i);
    ldData = vecMem[i];
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  task automatic fillVectors(input int n, input int lat);
    for (int i = 0; i < n; i++) begin
      vecMem[i] = {$urandom, $urandom, 2'($urandom), 2'($urandom), $urandom};
      modeArr[i] = M_OK;
      latArr[i] = lat;
      ovfArr[i] = 1'b0;
      yBad[i] = vecMem[i][31:0] ^ (32'h1 << $urandom_range(31, 0));
      @(negedge clk);
      ldEn = 1'b1;
      ldAddr = AW'(i);
      ldData = vecMem[i];
    end
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  // Expected outcome of a replay, straight from the scoring rules.
  task automatic refModel(input int n, output int p, output int f, output int e,
                          output int o, output int cyc);
    p = 0; f = 0; e = 0; o = 0; cyc = 1;
    for (int i = 0; i < n; i++) begin
      if (modeArr[i] == M_NODONE) begin
        f++;
        cyc += 3 + (TIMEOUT - 1);
      end else begin
        cyc += 3 + latArr[i];
        if (modeArr[i] == M_ERR) e++;
        else if (modeArr[i] == M_BADY) f++;
        else p++;
        if (ovfArr[i]) o++;
      end
    end
  endtask

  // Starts a replay and returns the number of rising edges until FIN.
  task automatic runSeq(input int nv, output int finAt, output int busyLow);
    startCnt = 0;
    mmCnt = 0;
    mmCycle = -1;
    opErr = 0;
    finAt = -1;
    busyLow = 0;
    @(negedge clk);
    numVec = (AW+1)'(nv);
    run = 1'b1;
    for (int k = 1; k <= 20000 && finAt < 0; k++) begin
      @(posedge clk);
      #1;
      if (fin) finAt = k;
      else if (!busy) busyLow++;
    end
    nChecks++;
    if (finAt < 0) begin
      nErrors++;
      $display("[TB] FAIL fin_timeout: FIN never rose, required within 20000 cycles");
    end
  endtask

  task automatic finishRun(input string tag, input int expPass);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    nChecks++;
    if (fin !== 1'b0 || busy !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL %s_release: fin=%b busy=%b, required 0 0", tag, fin, busy);
    end
    nChecks++;
    if (int'(passCnt) !== expPass) begin
      nErrors++;
      $display("[TB] FAIL %s_held: pass_cnt=%0d, required %0d", tag, passCnt, expPass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nChecks++;
    if ({start, busy, mismatch, fin} !== 4'b0) begin
      nErrors++;
      $display("[TB] FAIL reset_flags: start/busy/mismatch/fin=%b, required 0000",
               {start, busy, mismatch, fin});
    end
    nChecks++;
    if ({passCnt, failCnt, errCnt, ovfCnt} !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset_counters: %0d %0d %0d %0d, required all 0",
               passCnt, failCnt, errCnt, ovfCnt);
    end
    nChecks++;
    if ({opA, opB, opSel, opRnd} !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset_operands: A=%h B=%h, required 0", opA, opB);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int finAt, busyLow;
    fillVectors(3, 2);
    runSeq(3, finAt, busyLow);
    nChecks++;
    if (finAt !== 16) begin
      nErrors++;
      $display("[TB] FAIL basic_fin_cycle: FIN at %0d, required 16", finAt);
    end
    nChecks++;
    if (int'(passCnt) !== 3 || int'(failCnt) !== 0) begin
      nErrors++;
      $display("[TB] FAIL basic_counts: pass=%0d fail=%0d, required 3 0", passCnt, failCnt);
    end
    nChecks++;
    if (startCnt !== 3 || mmCnt !== 0 || opErr !== 0 || busyLow !== 0) begin
      nErrors++;
      $display("[TB] FAIL basic_traffic: starts=%0d mm=%0d operr=%0d busylow=%0d, required 3 0 0 0",
               startCnt, mmCnt, opErr, busyLow);
    end
    finishRun("basic", 3);
  endtask

  task automatic test_mismatch();
    int finAt, busyLow;
    fillVectors(3, 2);
    vecMem[1][31:0] = 32'h3F80_0000;
    yBad[1] = 32'h3F80_0001;
    modeArr[1] = M_BADY;
    loadOne(1);
    runSeq(3, finAt, busyLow);
    nChecks++;
    if (mmCnt !== 1) begin
      nErrors++;
      $display("[TB] FAIL mismatch_pulses: %0d pulses, required 1", mmCnt);
    end
    nChecks++;
    if (int'(failCnt) !== 1 || int'(passCnt) !== 2) begin
      nErrors++;
      $display("[TB] FAIL mismatch_counts: pass=%0d fail=%0d, required 2 1", passCnt, failCnt);
    end
    finishRun("mismatch", 2);
  endtask

  task automatic test_timeout();
    int finAt, busyLow;
    fillVectors(3, 2);
    modeArr[1] = M_NODONE;
    runSeq(3, finAt, busyLow);
    nChecks++;
    if (mmCycle !== startCycle[1] + 8) begin
      nErrors++;
      $display("[TB] FAIL timeout_check_cycle: CHECK %0d cycles after start, required 8",
               mmCycle - startCycle[1]);
    end
    nChecks++;
    if (int'(failCnt) !== 1 || int'(passCnt) !== 2 || startCnt !== 3) begin
      nErrors++;
      $display("[TB] FAIL timeout_counts: pass=%0d fail=%0d starts=%0d, required 2 1 3",
               passCnt, failCnt, startCnt);
    end
    nChecks++;
    if (finAt !== 1 + 5 + 10 + 5) begin
      nErrors++;
      $display("[TB] FAIL timeout_fin_cycle: FIN at %0d, required 21", finAt);
    end
    finishRun("timeout", 2);
  endtask

  task automatic test_error_overflow();
    int finAt, busyLow;
    fillVectors(3, 3);
    modeArr[0] = M_ERR;
    ovfArr[1] = 1'b1;
    modeArr[2] = M_EARLY;
    runSeq(3, finAt, busyLow);
    nChecks++;
    if (int'(errCnt) !== 1 || int'(failCnt) !== 0 || int'(passCnt) !== 2) begin
      nErrors++;
      $display("[TB] FAIL errovf_counts: err=%0d fail=%0d pass=%0d, required 1 0 2",
               errCnt, failCnt, passCnt);
    end
    nChecks++;
    if (int'(ovfCnt) !== 1 || mmCnt !== 0) begin
      nErrors++;
      $display("[TB] FAIL errovf_ovf: ovf=%0d mm=%0d, required 1 0", ovfCnt, mmCnt);
    end
    finishRun("errovf", 2);
  endtask

  task automatic test_bounds();
    int finAt, busyLow;
    runSeq(0, finAt, busyLow);
    nChecks++;
    if (finAt !== 1 || startCnt !== 0) begin
      nErrors++;
      $display("[TB] FAIL zero_vec: FIN at %0d starts=%0d, required 1 0", finAt, startCnt);
    end
    finishRun("zero", 0);
    fillVectors(DEPTH, 1);
    runSeq(2047, finAt, busyLow);
    nChecks++;
    if (startCnt !== DEPTH || int'(passCnt) !== DEPTH) begin
      nErrors++;
      $display("[TB] FAIL clamp_starts: starts=%0d pass=%0d, required 1024 1024", startCnt, passCnt);
    end
    nChecks++;
    if (finAt !== 1 + DEPTH * 4 || opErr !== 0) begin
      nErrors++;
      $display("[TB] FAIL clamp_timing: FIN at %0d operr=%0d, required %0d 0",
               finAt, opErr, 1 + DEPTH * 4);
    end
    finishRun("clamp", DEPTH);
  endtask

  task automatic test_random();
    int finAt, busyLow, n, p, f, e, o, cyc;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(12, 4);
      fillVectors(n, 1);
      for (int i = 0; i < n; i++) begin
        modeArr[i] = $urandom_range(4, 0);
        latArr[i] = $urandom_range(TIMEOUT - 2, 1);
        ovfArr[i] = 1'($urandom_range(1, 0));
      end
      refModel(n, p, f, e, o, cyc);
      runSeq(n, finAt, busyLow);
      nChecks++;
      if (int'(passCnt) !== p || int'(failCnt) !== f || int'(errCnt) !== e || int'(ovfCnt) !== o) begin
        nErrors++;
        $display("[TB] FAIL random_counts it%0d: got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                 it, passCnt, failCnt, errCnt, ovfCnt, p, f, e, o);
      end
      nChecks++;
      if (finAt !== cyc || mmCnt !== f || startCnt !== n || opErr !== 0 || busyLow !== 0) begin
        nErrors++;
        $display("[TB] FAIL random_flow it%0d: fin=%0d mm=%0d starts=%0d operr=%0d busylow=%0d, required %0d %0d %0d 0 0",
                 it, finAt, mmCnt, startCnt, opErr, busyLow, cyc, f, n);
      end
      finishRun("random", p);
    end
  endtask

  task automatic test_reset_mid();
    int finAt, busyLow, guard;
    fillVectors(8, 2);
    latArr[5] = 6;
    startCnt = 0;
    opErr = 0;
    @(negedge clk);
    numVec = (AW+1)'(8);
    run = 1'b1;
    guard = 0;
    while (startCnt < 6 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    nChecks++;
    if (startCnt !== 6) begin
      nErrors++;
      $display("[TB] FAIL midreset_reach: starts=%0d, required 6", startCnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    nChecks++;
    if ({start, busy, mismatch, fin, passCnt, failCnt, errCnt, ovfCnt, opA, opB} !== '0) begin
      nErrors++;
      $display("[TB] FAIL midreset_clear: busy=%b pass=%0d A=%h, required all 0", busy, passCnt, opA);
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runSeq(3, finAt, busyLow);
    nChecks++;
    if (startCnt !== 3 || opErr !== 0 || int'(passCnt) !== 3 || finAt !== 16) begin
      nErrors++;
      $display("[TB] FAIL midreset_rerun: starts=%0d operr=%0d pass=%0d fin=%0d, required 3 0 3 16",
               startCnt, opErr, passCnt, finAt);
    end
    finishRun("rerun", 3);
  endtask

  initial begin
    $display("[TB] pattern_player bench starting");
    test_reset();
    test_basic();
    test_mismatch();
    test_timeout();
    test_error_overflow();
    test_bounds();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
